// File: rtl/sine_table_loader.sv
// sine_table_loader: streams host words into the quarter-wave sine table and keeps the synth muted until the table is whole.
// Optional running checksum of the session's words when SINE_TABLE_LOADER_CHECKSUM_EN is defined.
module sine_table_loader #(
    parameter int ADDRESS_WIDTH = 14,
    parameter int DATA_WIDTH    = 16,
    parameter int FLUSH_CYCLES  = 3
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     i_LoadStart,
    input  logic                     i_LoadAbort,
    input  logic                     i_DataValid,
    input  logic [DATA_WIDTH-1:0]    i_DataValue,
    output logic                     o_DataReady,
    output logic                     o_SineTableWriteEnable,
    output logic [ADDRESS_WIDTH-1:0] o_SineTableWriteAddress,
    output logic [DATA_WIDTH-1:0]    o_SineTableWriteValue,
    output logic                     o_Busy,
    output logic                     o_TableValid,
    output logic                     o_MuteOutput,
    output logic                     o_LoadDone,
    output logic                     o_LoadAborted
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]    o_Checksum
`endif
);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [ADDRESS_WIDTH:0] LAST = {1'b0, {ADDRESS_WIDTH{1'b1}}};
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;
    state_t                   state_q;
    logic [ADDRESS_WIDTH:0]   cnt_q;
    logic [FW-1:0]            fc_q;
    logic                     complete_q, ready_q, we_q, valid_q, mute_q, done_q, aborted_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    val_q;
    logic                     beat, last_beat;
    assign beat      = i_DataValid & ready_q;
    assign last_beat = beat && cnt_q == LAST;
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;
    assign o_Checksum = sum_q;
`endif
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            fc_q       <= '0;
            complete_q <= 1'b0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            valid_q    <= 1'b0;
            mute_q     <= 1'b1;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            addr_q     <= '0;
            val_q      <= '0;
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                IDLE: if (i_LoadStart) begin
                    state_q <= LOAD;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    mute_q  <= 1'b1;
                    cnt_q   <= '0;
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
                    sum_q   <= '0;
`endif
                end
                LOAD: begin
                    if (beat) begin
                        we_q   <= 1'b1;
                        addr_q <= cnt_q[ADDRESS_WIDTH-1:0];
                        val_q  <= i_DataValue;
                        cnt_q  <= cnt_q + 1'b1;
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
                        sum_q  <= sum_q + i_DataValue;
`endif
                    end
                    // completion outranks a coincident abort
                    if (last_beat || i_LoadAbort) begin
                        state_q    <= FLUSH;
                        ready_q    <= 1'b0;
                        fc_q       <= '0;
                        complete_q <= last_beat;
                    end
                end
                FLUSH: begin
                    fc_q      <= fc_q + 1'b1;
                    done_q    <= complete_q && fc_q == FW'(FLUSH_CYCLES - 1);
                    aborted_q <= !complete_q && fc_q == FW'(FLUSH_CYCLES - 1);
                    if (fc_q == FW'(FLUSH_CYCLES)) begin
                        state_q <= IDLE;
                        valid_q <= complete_q;
                        mute_q  <= !complete_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign o_DataReady             = ready_q;
    assign o_SineTableWriteEnable  = we_q;
    assign o_SineTableWriteAddress = addr_q;
    assign o_SineTableWriteValue   = val_q;
    assign o_Busy                  = state_q != IDLE;
    assign o_TableValid            = valid_q;
    assign o_MuteOutput            = mute_q;
    assign o_LoadDone              = done_q;
    assign o_LoadAborted           = aborted_q;
endmodule

// File: tb/tb_sine_table_loader.sv
// tb_sine_table_loader: randomized sessions with a scoreboard of expected table writes and done/abort pulses.
module tb_sine_table_loader;
    logic        i_Clock, i_Reset, i_LoadStart, i_LoadAbort, i_DataValid;
    logic [15:0] i_DataValue;
    logic        o_DataReady, o_SineTableWriteEnable, o_Busy, o_TableValid, o_MuteOutput, o_LoadDone, o_LoadAborted;
    logic [3:0]  o_SineTableWriteAddress;
    logic [15:0] o_SineTableWriteValue;
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
    logic [15:0] o_Checksum;
`endif
    sine_table_loader #(.ADDRESS_WIDTH(4), .DATA_WIDTH(16), .FLUSH_CYCLES(3)) dut (
        .i_Clock(i_Clock),
        .i_Reset(i_Reset),
        .i_LoadStart(i_LoadStart),
        .i_LoadAbort(i_LoadAbort),
        .i_DataValid(i_DataValid),
        .i_DataValue(i_DataValue),
        .o_DataReady(o_DataReady),
        .o_SineTableWriteEnable(o_SineTableWriteEnable),
        .o_SineTableWriteAddress(o_SineTableWriteAddress),
        .o_SineTableWriteValue(o_SineTableWriteValue),
        .o_Busy(o_Busy),
        .o_TableValid(o_TableValid),
        .o_MuteOutput(o_MuteOutput),
        .o_LoadDone(o_LoadDone),
        .o_LoadAborted(o_LoadAborted)
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
        ,
        .o_Checksum(o_Checksum)
`endif
    );
    typedef struct {int cyc; int addr; int val;} wr_t;
    typedef struct {int cyc; bit done;} ev_t;
    wr_t         wq[$];
    ev_t         evq[$];
    wr_t         we_e;
    ev_t         ev_e;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          mon_en = 0;
    logic [15:0] msum;
    initial begin
        i_Clock = 0;
        forever #5 i_Clock = ~i_Clock;
    end
    always @(posedge i_Clock) cyc <= cyc + 1;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask
    // every strobe/pulse must match the oldest expectation, including the cycle it was due
    always @(negedge i_Clock) if (mon_en) begin
        if (o_SineTableWriteEnable) begin
            check("write_expected", 32'(wq.size() > 0), 1);
            if (wq.size() > 0) begin
                we_e = wq.pop_front();
                check("write_cycle", cyc, we_e.cyc);
                check("write_addr", 32'(o_SineTableWriteAddress), we_e.addr);
                check("write_value", 32'(o_SineTableWriteValue), we_e.val);
            end
        end
        if (o_LoadDone || o_LoadAborted) begin
            check("pulse_expected", 32'(evq.size() > 0), 1);
            if (evq.size() > 0) begin
                ev_e = evq.pop_front();
                check("pulse_cycle", cyc, ev_e.cyc);
                check("done_pulse", 32'(o_LoadDone), 32'(ev_e.done));
                check("aborted_pulse", 32'(o_LoadAborted), 32'(!ev_e.done));
            end
        end
    end
    // wsel: 0 = 0x1000+i, 1 = random, 2 = all 0xFFFF
    task automatic run_session(input int abort_at, input bit abort_last, input bit gaps, input int rst_at, input int wsel);
        int          last;
        bit          complete;
        logic [15:0] w;
        complete = 0;
        last = cyc;
        i_LoadStart = 1;
        tick();
        i_LoadStart = 0;
        check("mute_after_start", 32'(o_MuteOutput), 1);
        check("busy_after_start", 32'(o_Busy), 1);
        check("tv_cleared", 32'(o_TableValid), 0);
        msum = 0;
        for (int i = 0; i < 16; i++) begin
            if (gaps) for (int g = 0; g < 6 && $urandom_range(0, 1) == 1; g++) begin
                check("ready_gap", 32'(o_DataReady), 1);
                i_LoadStart = 1'($urandom_range(0, 1));
                i_DataValue = 16'($urandom);
                tick();
                i_LoadStart = 0;
            end
            if (i == rst_at) begin
                i_Reset = 1;
                i_DataValid = 1;
                i_DataValue = 16'($urandom);
                tick();
                i_Reset = 0;
                i_DataValid = 0;
                check("rst_busy", 32'(o_Busy), 0);
                check("rst_mute", 32'(o_MuteOutput), 1);
                check("rst_tv", 32'(o_TableValid), 0);
                check("rst_ready", 32'(o_DataReady), 0);
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
                check("rst_checksum", 32'(o_Checksum), 0);
`endif
                repeat (4) tick();
                return;
            end
            check("ready_load", 32'(o_DataReady), 1);
            if (i == abort_at) begin
                i_LoadAbort = 1;
                evq.push_back('{cyc + 4, 1'b0});
                last = cyc;
                tick();
                i_LoadAbort = 0;
                break;
            end
            w = wsel == 0 ? 16'h1000 + 16'(i) : wsel == 1 ? 16'($urandom) : 16'hFFFF;
            i_DataValid = 1;
            i_DataValue = w;
            wq.push_back('{cyc + 1, i, int'(w)});
            msum += w;
            if (i == 15) begin
                evq.push_back('{cyc + 4, 1'b1});
                complete = 1;
                i_LoadAbort = abort_last;
            end
            last = cyc;
            tick();
            i_DataValid = 0;
            i_LoadAbort = 0;
        end
        while (cyc < last + 4) tick();
        check("flush_ready", 32'(o_DataReady), 0);
        check("flush_busy", 32'(o_Busy), 1);
        check("flush_mute", 32'(o_MuteOutput), 1);
        check("flush_tv", 32'(o_TableValid), 0);
        tick();
        check("end_tv", 32'(o_TableValid), 32'(complete));
        check("end_mute", 32'(o_MuteOutput), 32'(!complete));
        check("end_busy", 32'(o_Busy), 0);
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
        check("checksum", 32'(o_Checksum), 32'(msum));
`endif
    endtask
    initial begin
        i_Reset = 1;
        i_LoadStart = 0;
        i_LoadAbort = 0;
        i_DataValid = 0;
        i_DataValue = 0;
        repeat (3) tick();
        i_Reset = 0;
        mon_en = 1;
        for (int k = 0; k < 6; k++) begin
            check("idle_mute", 32'(o_MuteOutput), 1);
            check("idle_tv", 32'(o_TableValid), 0);
            check("idle_ready", 32'(o_DataReady), 0);
            check("idle_busy", 32'(o_Busy), 0);
            i_DataValid = 1'($urandom_range(0, 1));
            i_LoadAbort = 1'($urandom_range(0, 1));
            i_DataValue = 16'($urandom);
            tick();
        end
        i_DataValid = 0;
        i_LoadAbort = 0;
        tick();
        run_session(-1, 0, 0, -1, 0);
        run_session(-1, 0, 1, -1, 0);
        run_session(7, 0, 0, -1, 1);
        run_session(-1, 0, 1, -1, 1);
        run_session(-1, 1, 0, -1, 1);
        run_session(-1, 0, 0, 5, 1);
        run_session(-1, 0, 1, -1, 1);
        run_session(0, 0, 0, -1, 1);
        run_session(-1, 0, 0, -1, 2);
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
        check("checksum_ffff", 32'(o_Checksum), 32'h0000FFF0);
`endif
        repeat (5) tick();
        check("writes_drained", wq.size(), 0);
        check("pulses_drained", evq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
